// File: rtl/accumulator_binary_saturating_multichannel.sv
// Bank of signed saturating accumulators that share one add/subtract datapath.
// Commands come in over a valid/ready handshake. Each accepted command updates its channel
// on the accepting edge. It also produces one registered result beat.
module accumulator_binary_saturating_multichannel #(
    parameter int unsigned WORD_WIDTH                 = 16,
    parameter int unsigned CHANNEL_COUNT              = 4,
    parameter int unsigned CHANNEL_ADDR_WIDTH         = 2,
    parameter logic [WORD_WIDTH-1:0] INITIAL_VALUE    = '0
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [CHANNEL_ADDR_WIDTH-1:0] input_channel,
    input  logic [1:0]                    input_opcode,
    input  logic [WORD_WIDTH-1:0]         input_operand,
    input  logic [WORD_WIDTH-1:0]         max_limit,
    input  logic [WORD_WIDTH-1:0]         min_limit,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [CHANNEL_ADDR_WIDTH-1:0] output_channel,
    output logic [WORD_WIDTH-1:0]         output_value,
    output logic                          output_overflow,
    output logic                          output_sticky_overflow
);

    localparam logic [1:0] OpAdd   = 2'b00;
    localparam logic [1:0] OpSub   = 2'b01;
    localparam logic [1:0] OpLoad  = 2'b10;
    localparam logic [1:0] OpReset = 2'b11;

    // One extra bit, so an unsigned compare with CHANNEL_COUNT cannot truncate.
    localparam logic [CHANNEL_ADDR_WIDTH:0] ChannelLimit =
        (CHANNEL_ADDR_WIDTH + 1)'(CHANNEL_COUNT);

    // Per-channel architectural state.
    logic [WORD_WIDTH-1:0] value_q  [CHANNEL_COUNT];
    logic                  sticky_q [CHANNEL_COUNT];

    // Single-entry output register.
    logic                          out_valid_q;
    logic [CHANNEL_ADDR_WIDTH-1:0] out_channel_q;
    logic [WORD_WIDTH-1:0]         out_value_q;
    logic                          out_overflow_q;
    logic                          out_sticky_q;

    logic                         accept;
    logic                         in_range;
    logic [WORD_WIDTH-1:0]        cur_value;
    logic                         cur_sticky;
    logic signed [WORD_WIDTH:0]   acc_ext;
    logic signed [WORD_WIDTH:0]   opd_ext;
    logic signed [WORD_WIDTH:0]   max_ext;
    logic signed [WORD_WIDTH:0]   min_ext;
    logic signed [WORD_WIDTH:0]   sum;
    logic [WORD_WIDTH-1:0]        new_value;
    logic                         new_overflow;
    logic                         new_sticky;

    assign input_ready = !out_valid_q || output_ready;
    assign accept      = input_valid && input_ready;
    assign in_range    = {1'b0, input_channel} < ChannelLimit;

    // Compute the next channel value, overflow and sticky flag for the command presented now.
    always_comb begin
        cur_value    = '0;
        cur_sticky   = 1'b0;
        if (in_range) begin
            cur_value  = value_q[input_channel];
            cur_sticky = sticky_q[input_channel];
        end
        // Sign-extend by one bit, so add/subtract can never wrap internally.
        acc_ext      = $signed({cur_value[WORD_WIDTH-1], cur_value});
        opd_ext      = $signed({input_operand[WORD_WIDTH-1], input_operand});
        max_ext      = $signed({max_limit[WORD_WIDTH-1], max_limit});
        min_ext      = $signed({min_limit[WORD_WIDTH-1], min_limit});
        sum          = (input_opcode == OpSub) ? (acc_ext - opd_ext) : (acc_ext + opd_ext);
        new_value    = '0;
        new_overflow = 1'b0;
        new_sticky   = 1'b0;
        case (input_opcode)
            OpAdd, OpSub: begin
                // The max bound wins when the limits are inverted.
                if (sum > max_ext) begin
                    new_value    = max_limit;
                    new_overflow = 1'b1;
                end else if (sum < min_ext) begin
                    new_value    = min_limit;
                    new_overflow = 1'b1;
                end else begin
                    new_value    = sum[WORD_WIDTH-1:0];
                end
                new_sticky = cur_sticky || new_overflow;
            end
            OpLoad: begin
                new_value = input_operand;
            end
            OpReset: begin
                new_value = INITIAL_VALUE;
            end
            default: begin
                new_value = '0;
            end
        endcase
    end

    // Channel state: written at accept. clear returns every channel to its initial state.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
                value_q[i]  <= INITIAL_VALUE;
                sticky_q[i] <= 1'b0;
            end
        end else if (accept && in_range) begin
            value_q[input_channel]  <= new_value;
            sticky_q[input_channel] <= new_sticky;
        end
    end

    // Result register: loads on accept, empties on handshake, holds under backpressure.
    always_ff @(posedge clock) begin
        if (clear) begin
            out_valid_q    <= 1'b0;
            out_channel_q  <= '0;
            out_value_q    <= '0;
            out_overflow_q <= 1'b0;
            out_sticky_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q    <= 1'b1;
            out_channel_q  <= input_channel;
            // An out-of-range channel reports zero and no flags.
            out_value_q    <= in_range ? new_value : '0;
            out_overflow_q <= in_range && new_overflow;
            out_sticky_q   <= in_range && new_sticky;
        end else if (output_ready) begin
            out_valid_q    <= 1'b0;
        end
    end

    assign output_valid           = out_valid_q;
    assign output_channel         = out_channel_q;
    assign output_value           = out_value_q;
    assign output_overflow        = out_overflow_q;
    assign output_sticky_overflow = out_sticky_q;

endmodule

// File: tb/tb_accumulator_binary_saturating_multichannel.sv
// Bench for the multichannel saturating accumulator.
// Runs with WORD_WIDTH=8 and CHANNEL_COUNT=3, so channel 3 is out of range.
module tb_accumulator_binary_saturating_multichannel;

    localparam int unsigned W  = 8;
    localparam int unsigned CC = 3;
    localparam int unsigned AW = 2;

    logic          clock = 1'b0;
    logic          clear;
    logic          input_valid;
    logic          input_ready;
    logic [AW-1:0] input_channel;
    logic [1:0]    input_opcode;
    logic [W-1:0]  input_operand;
    logic [W-1:0]  max_limit;
    logic [W-1:0]  min_limit;
    logic          output_valid;
    logic          output_ready;
    logic [AW-1:0] output_channel;
    logic [W-1:0]  output_value;
    logic          output_overflow;
    logic          output_sticky_overflow;

    accumulator_binary_saturating_multichannel #(
        .WORD_WIDTH         (W),
        .CHANNEL_COUNT      (CC),
        .CHANNEL_ADDR_WIDTH (AW),
        .INITIAL_VALUE      (8'd0)
    ) dut (
        .clock                  (clock),
        .clear                  (clear),
        .input_valid            (input_valid),
        .input_ready            (input_ready),
        .input_channel          (input_channel),
        .input_opcode           (input_opcode),
        .input_operand          (input_operand),
        .max_limit              (max_limit),
        .min_limit              (min_limit),
        .output_valid           (output_valid),
        .output_ready           (output_ready),
        .output_channel         (output_channel),
        .output_value           (output_value),
        .output_overflow        (output_overflow),
        .output_sticky_overflow (output_sticky_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int val;
        int ovf;
        int sticky;
    } beat_t;

    typedef struct {
        int ch;
        int op;
        int operand;
        int maxl;
        int minl;
        int ev;
        int eo;
        int es;
    } vec_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Scoreboard: a beat is consumed on the edge after a negedge that sees valid && ready.
    always @(negedge clock) begin
        beat_t b;
        if (!clear && output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                chk("beat_channel", int'(output_channel), b.ch);
                chk("beat_value", int'($signed(output_value)), b.val);
                chk("beat_overflow", int'(output_overflow), b.ovf);
                chk("beat_sticky", int'(output_sticky_overflow), b.sticky);
            end
        end
    end

    // Drive one command and wait, with a bound, for its accept. Push its expected beat then.
    task automatic send(input int ch, input int op, input int operand, input int maxl,
                        input int minl, input int ev, input int eo, input int es);
        bit accepted;
        int n;
        beat_t b;
        input_channel = AW'(ch);
        input_opcode  = 2'(op);
        input_operand = W'(operand);
        max_limit     = W'(maxl);
        min_limit     = W'(minl);
        input_valid   = 1'b1;
        accepted      = 1'b0;
        n             = 0;
        while (!accepted && n < 50) begin
            @(negedge clock);
            if (input_ready && !clear) begin
                b.ch = ch; b.val = ev; b.ovf = eo; b.sticky = es;
                exp_q.push_back(b);
                accepted = 1'b1;
            end
            @(posedge clock);
            #1;
            n++;
        end
        input_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        // ch, op, operand, max, min, exp value, exp ovf, exp sticky
        vecs.push_back('{1, 0,   30, 100, -100,   30, 0, 0});
        vecs.push_back('{1, 0,   30, 100, -100,   60, 0, 0});
        vecs.push_back('{1, 0,   30, 100, -100,   90, 0, 0});
        vecs.push_back('{0, 0,    0, 100, -100,    0, 0, 0});
        vecs.push_back('{2, 0,    0, 100, -100,    0, 0, 0});
        vecs.push_back('{3, 0,    0, 100, -100,    0, 0, 0});
        vecs.push_back('{1, 0,   20, 100, -100,  100, 1, 1});
        vecs.push_back('{1, 0,   -5, 100, -100,   95, 0, 1});
        vecs.push_back('{2, 2, -128, 100, -100, -128, 0, 0});
        vecs.push_back('{2, 1,  127, 100, -100, -100, 1, 1});
        vecs.push_back('{1, 3,   55, 100, -100,    0, 0, 0});
        vecs.push_back('{3, 0,    7, 100, -100,    0, 0, 0});
        vecs.push_back('{1, 0,    0, 100, -100,    0, 0, 0});
        vecs.push_back('{2, 0,    0, 100, -100, -100, 0, 1});
        vecs.push_back('{0, 0,   15,  10,   20,   10, 1, 1});
        vecs.push_back('{0, 0,    0,  10,   20,   20, 1, 1});
        vecs.push_back('{0, 2,  127, 100, -100,  127, 0, 0});
        vecs.push_back('{2, 1, -100, 100, -100,    0, 0, 1});

        clear         = 1'b1;
        output_ready  = 1'b1;
        input_valid   = 1'b1;
        input_channel = 2'd1;
        input_opcode  = 2'd0;
        input_operand = 8'd9;
        max_limit     = 8'd100;
        min_limit     = 8'd156;
        repeat (3) @(posedge clock);
        #1;
        input_valid = 1'b0;
        clear       = 1'b0;
        @(negedge clock);
        chk("reset_output_valid", int'(output_valid), 0);
        chk("reset_input_ready", int'(input_ready), 1);
        @(posedge clock);
        #1;

        // Back-to-back table, with the consumer always ready.
        foreach (vecs[i]) begin
            send(vecs[i].ch, vecs[i].op, vecs[i].operand, vecs[i].maxl, vecs[i].minl,
                 vecs[i].ev, vecs[i].eo, vecs[i].es);
        end
        repeat (2) @(posedge clock);
        #1;

        // Backpressure: the held command must wait, and the pending beat must not move.
        output_ready = 1'b0;
        send(1, 0, 5, 100, -100, 5, 0, 0);
        input_channel = 2'd1;
        input_opcode  = 2'd0;
        input_operand = 8'd5;
        input_valid   = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("bp_input_ready", int'(input_ready), 0);
            chk("bp_output_valid", int'(output_valid), 1);
            chk("bp_output_value", int'($signed(output_value)), 5);
            chk("bp_output_channel", int'(output_channel), 1);
        end
        @(posedge clock);
        #1;
        output_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_input_ready", int'(input_ready), 1);
        begin
            beat_t b;
            b.ch = 1; b.val = 10; b.ovf = 0; b.sticky = 0;
            exp_q.push_back(b);
        end
        @(posedge clock);
        #1;
        input_valid = 1'b0;
        @(negedge clock);
        chk("bp_held_beat_valid", int'(output_valid), 1);
        @(posedge clock);
        #1;

        // clear mid-stream: the pending beat is dropped, and so is the command presented with it.
        output_ready = 1'b0;
        send(1, 0, 3, 100, -100, 13, 0, 0);
        input_channel = 2'd2;
        input_opcode  = 2'd0;
        input_operand = 8'd1;
        input_valid   = 1'b1;
        clear         = 1'b1;
        @(posedge clock);
        #1;
        clear       = 1'b0;
        input_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("clear_output_valid", int'(output_valid), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("clear_no_late_beat", int'(output_valid), 0);
        @(posedge clock);
        #1;
        output_ready = 1'b1;
        send(0, 0, 0, 100, -100, 0, 0, 0);
        send(1, 0, 0, 100, -100, 0, 0, 0);
        send(2, 0, 0, 100, -100, 0, 0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
